stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Parametrised successor to the fixed 5-phase stage counter that drives the multi-phase CPU datapath.
- Generates per-stage activity and commit strobes for NUM_STAGES stages, in place of derived stage clocks.
- Adds per-stage wait on a ready input, global stall, per-instruction stage skipping, flush and halt.
- Sits at the CPU top; stage_commit[k] becomes the enable of every register owned by stage k (pc, regfile write, mem strobes).

Parameters:
NUM_STAGES, 5, number of stages (2..16); index 0 = IF.
STAGE_W, $clog2(NUM_STAGES), width of stage_idx.
CNT_W, 32, width of performance counters.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
stall  in  1  hold current stage; no commit while high
flush  in  1  abandon current instruction, restart at stage 0
halt  in  1  stop at the next instruction boundary while high
stage_ready  in  NUM_STAGES  stage k may complete (e.g. mem ack); tie high for fixed-latency stages
skip_mask  in  NUM_STAGES  stages to skip for the current instruction; bit 0 ignored
stage_idx  out  STAGE_W  current stage index
stage_act  out  NUM_STAGES  one-hot level, high while in that stage
stage_commit  out  NUM_STAGES  one-hot single-cycle pulse, stage completes this cycle
inst_retire  out  1  pulse on commit of the final executed stage of an instruction
halted  out  1  sequencer parked in HALTED
retired_cnt  out  CNT_W  instructions retired (optional feature)
stall_cnt  out  CNT_W  cycles with act but no commit (optional feature)

Behaviour:
- States: IDLE, RUN, HALTED.
- Reset (rst low, asynchronous): state IDLE; stage_idx=0; stage_act=0; stage_commit=0; inst_retire=0; halted=0; counters=0.
- IDLE: one cycle after rst deasserts, go to RUN with stage_idx=0. stage_act[0] rises in the 2nd rising edge after release.
- RUN: stage_act = onehot(stage_idx). Combinational commit rule:
  - stage_commit[s] = stage_act[s] & stage_ready[s] & ~stall & ~flush.
- No commit means stay in stage s. That cycle counts as a stall cycle.
- On commit of stage s, next stage = lowest k > s with skip_mask[k]=0.
  - skip_mask is sampled at that commit.
  - If no such k exists, this is the final stage: inst_retire=1 that cycle, next stage=0.
- Halt: sampled at final-stage commit. If high, go to HALTED instead of stage 0.
- HALTED: stage_act=0, halted=1. When halt is low, return to RUN at stage 0 on the next edge.
- flush in RUN: highest priority. No commit, no retire; next stage_idx=0, state RUN. Flush while at stage 0 simply holds stage 0 for one cycle.
- flush in HALTED or IDLE: no effect.
- Simultaneous stall and flush: flush wins.
- Simultaneous halt and flush: flush wins; halt is seen at the next instruction boundary.
- NUM_STAGES=2 with bit 1 skipped: every stage-0 commit retires (1 cycle/instruction).
- Asserting rst mid-instruction aborts immediately; no commit or retire is produced.
- stage_commit and inst_retire are combinational from registered state and inputs. All other outputs are registered.

Optional Feature:
- Macro: STAGE_SEQUENCER_PERF_CNT_EN.
- Defined:
  - retired_cnt increments on inst_retire.
  - stall_cnt increments on any cycle in RUN with no commit and no flush.
  - Both saturate at all-ones and clear only on reset.
- Undefined: the ports remain and are tied to 0; no counter registers are synthesised.

Decomposition:
- Shared package/defines: state encoding (SEQ_IDLE, SEQ_RUN, SEQ_HALTED) and a default stage-index constant per CPU stage (STG_IF, STG_ID, STG_EX, STG_MEM, STG_WB).
- One natural sub-module: seq_next_stage. It is combinational: given stage_idx and skip_mask, it returns next_idx and is_last.

Test Plan:
- Reset release, all ready, no skip, NUM_STAGES=5 -> stage_idx cycles 0,1,2,3,4,0; inst_retire every 5th cycle; retired_cnt=4 after 20 RUN cycles.
- stage_ready[3] low for 3 cycles at stage 3 -> stage_act[3] held 4 cycles; single stage_commit[3]; stall_cnt=3.
- skip_mask=5'b01000 sampled at stage 2 commit -> stage sequence 2,4; retire on stage 4 commit; 4 cycles/instruction.
- flush asserted at stage 3 with stall also high -> no commit or retire; stage_idx=0 next cycle.
- halt high during stage 2 -> stage 4 commit retires, halted=1, stage_act=0; halt low -> stage 0 active one cycle later.
- rst pulled low at stage 3 -> all outputs 0 asynchronously; restart at stage 0 after release, counters 0.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stage_sequencer_pkg
//
// Shared definitions for the multi-phase CPU stage sequencer:
//   - seq_state_e : sequencer state encoding (IDLE, RUN, HALTED)
//   - STG_*       : default stage index for each classic CPU stage. Stage 0
//                   is always instruction fetch and is where every
//                   instruction starts.
// -----------------------------------------------------------------------------
package stage_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_RUN    = 2'd1,
        SEQ_HALTED = 2'd2
    } seq_state_e;

    // Default stage positions for the five-stage datapath.
    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

endpackage : stage_sequencer_pkg

// File: rtl/stage_sequencer_seq_next_stage.sv
// -----------------------------------------------------------------------------
// seq_next_stage
//
// Purely combinational successor lookup for the stage sequencer. Given the
// current stage and the skip mask of the instruction in flight, it returns
// the lowest stage above the current one that is not skipped. When every
// higher stage is skipped (or none exists), the current stage is the final
// stage of the instruction: is_last is raised and next_idx wraps to 0.
//
// Ports:
//   stage_idx  in   STAGE_W     current stage index
//   skip_mask  in   NUM_STAGES  stages skipped by this instruction (bit 0
//                               can never be a successor, so it has no effect)
//   next_idx   out  STAGE_W     stage to enter after the current one commits
//   is_last    out  1           current stage is the final executed stage
// -----------------------------------------------------------------------------
module seq_next_stage #(
    parameter int NUM_STAGES = 5,
    parameter int STAGE_W    = $clog2(NUM_STAGES)
) (
    input  logic [STAGE_W-1:0]    stage_idx,
    input  logic [NUM_STAGES-1:0] skip_mask,
    output logic [STAGE_W-1:0]    next_idx,
    output logic                  is_last
);

    // Scan from the top down so the last hit, i.e. the lowest qualifying
    // stage, is the one that sticks. Stage 0 is never above the current
    // stage, so its skip bit is naturally ignored.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise a latch is inferred.
        next_idx = '0;
        is_last  = 1'b1;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if ((k > int'(stage_idx)) && !skip_mask[k]) begin
                next_idx = STAGE_W'(k);
                is_last  = 1'b0;
            end
        end
    end

endmodule : seq_next_stage

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Drives the multi-phase CPU datapath with per-stage activity levels and
// commit strobes instead of derived stage clocks. Every register owned by
// stage k uses stage_commit[k] as its enable.
//
// Instruction flow: stages run in index order starting at stage 0. A stage
// commits when it is active, its stage_ready bit is high and neither stall
// nor flush is asserted. After a commit the sequencer moves to the lowest
// higher stage not marked in skip_mask (sampled at that commit); when none
// remains the instruction retires and the sequencer returns to stage 0, or
// parks in HALTED if halt is high at that retiring commit. flush abandons
// the instruction in flight and restarts at stage 0 without a commit.
//
// Parameters:
//   NUM_STAGES  number of stages (2..16), index 0 = instruction fetch
//   STAGE_W     width of stage_idx
//   CNT_W       width of the performance counters
//
// Ports:
//   clk           in   1           system clock
//   rst           in   1           asynchronous active-low reset
//   stall         in   1           hold the current stage, no commit
//   flush         in   1           abandon instruction, restart at stage 0
//   halt          in   1           park at the next instruction boundary
//   stage_ready   in   NUM_STAGES  stage k may complete this cycle
//   skip_mask     in   NUM_STAGES  stages skipped by the current instruction
//   stage_idx     out  STAGE_W     current stage index (registered)
//   stage_act     out  NUM_STAGES  one-hot, high while in that stage (registered)
//   stage_commit  out  NUM_STAGES  one-hot pulse, stage completes this cycle
//   inst_retire   out  1           final executed stage commits this cycle
//   halted        out  1           sequencer parked in HALTED (registered)
//   retired_cnt   out  CNT_W       retired instruction count
//   stall_cnt     out  CNT_W       RUN cycles without commit or flush
//
// Build option:
//   STAGE_SEQUENCER_PERF_CNT_EN  when defined, retired_cnt and stall_cnt are
//   saturating counters cleared only by reset; otherwise both ports are tied
//   to zero and no counter registers exist.
// -----------------------------------------------------------------------------
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int STAGE_W    = $clog2(NUM_STAGES),
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  halt,
    input  logic [NUM_STAGES-1:0] stage_ready,
    input  logic [NUM_STAGES-1:0] skip_mask,
    output logic [STAGE_W-1:0]    stage_idx,
    output logic [NUM_STAGES-1:0] stage_act,
    output logic [NUM_STAGES-1:0] stage_commit,
    output logic                  inst_retire,
    output logic                  halted,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [STAGE_W-1:0] FIRST_STAGE = STAGE_W'(STG_IF);

    seq_state_e            state_q;
    seq_state_e            state_d;
    logic                  idle_armed_q;
    logic                  idle_armed_d;
    logic [STAGE_W-1:0]    idx_d;
    logic [NUM_STAGES-1:0] act_d;
    logic                  halted_d;

    logic [STAGE_W-1:0]    next_idx;
    logic                  is_last;
    logic                  any_commit;

    // -------------------------------------------------------------------------
    // Successor lookup for the stage currently active
    // -------------------------------------------------------------------------
    seq_next_stage #(
        .NUM_STAGES (NUM_STAGES),
        .STAGE_W    (STAGE_W)
    ) u_next_stage (
        .stage_idx  (stage_idx),
        .skip_mask  (skip_mask),
        .next_idx   (next_idx),
        .is_last    (is_last)
    );

    // -------------------------------------------------------------------------
    // Commit and retire strobes
    // -------------------------------------------------------------------------
    // stage_act is all-zero outside RUN and is cleared asynchronously by
    // reset, so no explicit state qualification is needed: a commit can only
    // happen in RUN, and a reset mid-instruction kills the strobe at once.
    assign stage_commit = stage_act & stage_ready & {NUM_STAGES{~stall & ~flush}};
    assign any_commit   = |stage_commit;
    assign inst_retire  = any_commit & is_last;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idle_armed_d = idle_armed_q;
        idx_d        = stage_idx;

        unique case (state_q)
            // IDLE lasts one full cycle after the first edge following reset
            // release, so stage 0 becomes active on the second edge.
            SEQ_IDLE: begin
                idle_armed_d = 1'b1;
                if (idle_armed_q) begin
                    state_d = SEQ_RUN;
                    idx_d   = FIRST_STAGE;
                end
            end

            SEQ_RUN: begin
                if (flush) begin
                    // Flush outranks stall and halt; halt is looked at again
                    // at the next instruction boundary.
                    idx_d = FIRST_STAGE;
                end else if (any_commit) begin
                    if (is_last) begin
                        idx_d = FIRST_STAGE;
                        if (halt) begin
                            state_d = SEQ_HALTED;
                        end
                    end else begin
                        idx_d = next_idx;
                    end
                end
            end

            SEQ_HALTED: begin
                if (!halt) begin
                    state_d = SEQ_RUN;
                    idx_d   = FIRST_STAGE;
                end
            end

            default: begin
                state_d = SEQ_IDLE;
                idx_d   = FIRST_STAGE;
            end
        endcase

        // Registered outputs are decoded from the next state so they change
        // together with the state register.
        act_d = '0;
        if (state_d == SEQ_RUN) begin
            act_d[idx_d] = 1'b1;
        end
        halted_d = (state_d == SEQ_HALTED);
    end

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SEQ_IDLE;
            idle_armed_q <= 1'b0;
            stage_idx    <= FIRST_STAGE;
            stage_act    <= '0;
            halted       <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples the pre-edge values of the others.
            state_q      <= state_d;
            idle_armed_q <= idle_armed_d;
            stage_idx    <= idx_d;
            stage_act    <= act_d;
            halted       <= halted_d;
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef STAGE_SEQUENCER_PERF_CNT_EN
    logic             stall_cycle;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] stall_q;

    // A flushed cycle is not a stall: the stage is abandoned, not waiting.
    assign stall_cycle = (state_q == SEQ_RUN) & ~any_commit & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (inst_retire && (retired_q != '1)) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (stall_cycle && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`else
    assign retired_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule : stage_sequencer

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Self-checking bench for stage_sequencer (NUM_STAGES=5) plus a small
// NUM_STAGES=2 instance with stage 1 always skipped. A behavioural model
// tracks the instruction position as a plain stage number and computes the
// successor from the list of remaining unskipped stages.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    localparam int NS = 5;
    localparam int SW = $clog2(NS);
    localparam int CW = 32;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          halt  = 1'b0;
    logic [NS-1:0] stage_ready = '1;
    logic [NS-1:0] skip_mask   = '0;

    logic [SW-1:0] stage_idx;
    logic [NS-1:0] stage_act;
    logic [NS-1:0] stage_commit;
    logic          inst_retire;
    logic          halted;
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] stall_cnt;

    // Two-stage instance: stage 1 skipped, so every instruction is stage 0.
    logic          stall2 = 1'b0;
    logic          flush2 = 1'b0;
    logic          halt2  = 1'b0;
    logic [1:0]    ready2 = 2'b11;
    logic [1:0]    skip2  = 2'b10;
    logic [0:0]    idx2;
    logic [1:0]    act2;
    logic [1:0]    commit2;
    logic          retire2;
    logic          halted2;
    logic [CW-1:0] rcnt2;
    logic [CW-1:0] scnt2;

    int n_checks = 0;
    int n_fail   = 0;

    stage_sequencer #(.NUM_STAGES(NS), .CNT_W(CW)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .halt         (halt),
        .stage_ready  (stage_ready),
        .skip_mask    (skip_mask),
        .stage_idx    (stage_idx),
        .stage_act    (stage_act),
        .stage_commit (stage_commit),
        .inst_retire  (inst_retire),
        .halted       (halted),
        .retired_cnt  (retired_cnt),
        .stall_cnt    (stall_cnt)
    );

    stage_sequencer #(.NUM_STAGES(2), .CNT_W(CW)) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall2),
        .flush        (flush2),
        .halt         (halt2),
        .stage_ready  (ready2),
        .skip_mask    (skip2),
        .stage_idx    (idx2),
        .stage_act    (act2),
        .stage_commit (commit2),
        .inst_retire  (retire2),
        .halted       (halted2),
        .retired_cnt  (rcnt2),
        .stall_cnt    (scnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Checking helper
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    bit     m_running;
    bit     m_halted;
    int     m_wake;
    int     m_stage;
    longint m_ret;
    longint m_stall;
    localparam longint CNT_MAX = 64'hFFFF_FFFF;

    task automatic model_reset();
        m_running = 1'b0;
        m_halted  = 1'b0;
        m_wake    = 0;
        m_stage   = 0;
        m_ret     = 0;
        m_stall   = 0;
    endtask

    // Next executed stage after s, or -1 when s is the last one.
    function automatic int next_after(input int s, input logic [NS-1:0] skp);
        int rest[$];
        for (int k = s + 1; k < NS; k++) begin
            if (!skp[k]) rest.push_back(k);
        end
        return (rest.size() == 0) ? -1 : rest[0];
    endfunction

    function automatic logic [31:0] exp_cnt(input longint v);
`ifdef STAGE_SEQUENCER_PERF_CNT_EN
        return 32'(v);
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic model_compare();
        logic [NS-1:0] e_act;
        logic [NS-1:0] e_com;
        logic          e_ret;
        e_act = '0;
        if (m_running) e_act[m_stage] = 1'b1;
        e_com = (m_running && stage_ready[m_stage] && !stall && !flush) ? e_act : '0;
        e_ret = (e_com != '0) && (next_after(m_stage, skip_mask) < 0);
        check("model_act",     32'(stage_act),    32'(e_act));
        check("model_idx",     32'(stage_idx),    m_running ? 32'(m_stage) : 32'd0);
        check("model_commit",  32'(stage_commit), 32'(e_com));
        check("model_retire",  32'(inst_retire),  32'(e_ret));
        check("model_halted",  32'(halted),       32'(m_halted));
        check("model_retired_cnt", retired_cnt,   exp_cnt(m_ret));
        check("model_stall_cnt",   stall_cnt,     exp_cnt(m_stall));
    endtask

    // Apply the current inputs' effect at the coming clock edge.
    task automatic model_update();
        int nxt;
        if (m_halted) begin
            if (!halt) begin
                m_halted  = 1'b0;
                m_running = 1'b1;
                m_stage   = 0;
            end
        end else if (!m_running) begin
            m_wake++;
            if (m_wake >= 2) begin
                m_running = 1'b1;
                m_stage   = 0;
            end
        end else if (flush) begin
            m_stage = 0;
        end else if (stage_ready[m_stage] && !stall) begin
            nxt = next_after(m_stage, skip_mask);
            if (nxt < 0) begin
                if (m_ret < CNT_MAX) m_ret++;
                m_stage = 0;
                if (halt) begin
                    m_halted  = 1'b1;
                    m_running = 1'b0;
                end
            end else begin
                m_stage = nxt;
            end
        end else begin
            if (m_stall < CNT_MAX) m_stall++;
        end
    endtask

    // Inputs are driven right after a falling edge; outputs sampled 1ns later.
    task automatic apply(input logic st, input logic fl, input logic hl,
                         input logic [NS-1:0] rdy, input logic [NS-1:0] skp);
        stall       = st;
        flush       = fl;
        halt        = hl;
        stage_ready = rdy;
        skip_mask   = skp;
        #1;
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    // Directed vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic          st;
        logic          fl;
        logic          hl;
        logic [NS-1:0] rdy;
        logic [NS-1:0] skp;
        int            e_idx;
        logic [NS-1:0] e_act;
        logic [NS-1:0] e_com;
        logic          e_ret;
        logic          e_halted;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic st, input logic fl, input logic hl,
                       input logic [NS-1:0] rdy, input logic [NS-1:0] skp,
                       input int idx, input logic [NS-1:0] act,
                       input logic [NS-1:0] com, input logic ret, input logic hlt);
        vec_t v;
        v.st = st; v.fl = fl; v.hl = hl; v.rdy = rdy; v.skp = skp;
        v.e_idx = idx; v.e_act = act; v.e_com = com; v.e_ret = ret; v.e_halted = hlt;
        vecs.push_back(v);
    endtask

    localparam logic [NS-1:0] ALL = 5'b11111;
    localparam logic [NS-1:0] NON = 5'b00000;

    initial begin
        logic hl_r;
        bit   reached;

        // Table: ready wait at stage 3, skip of stage 3, flush+stall,
        // halt, flush+halt at the last stage, flush at stage 0.
        row(0,0,0, ALL,      NON,      0, 5'b00001, 5'b00001, 0, 0);
        row(0,0,0, ALL,      NON,      1, 5'b00010, 5'b00010, 0, 0);
        row(0,0,0, ALL,      NON,      2, 5'b00100, 5'b00100, 0, 0);
        row(0,0,0, 5'b10111, NON,      3, 5'b01000, 5'b00000, 0, 0);
        row(0,0,0, 5'b10111, NON,      3, 5'b01000, 5'b00000, 0, 0);
        row(0,0,0, 5'b10111, NON,      3, 5'b01000, 5'b00000, 0, 0);
        row(0,0,0, ALL,      NON,      3, 5'b01000, 5'b01000, 0, 0);
        row(0,0,0, ALL,      NON,      4, 5'b10000, 5'b10000, 1, 0);
        row(0,0,0, ALL,      NON,      0, 5'b00001, 5'b00001, 0, 0);
        row(0,0,0, ALL,      NON,      1, 5'b00010, 5'b00010, 0, 0);
        row(0,0,0, ALL,      5'b01000, 2, 5'b00100, 5'b00100, 0, 0);
        row(0,0,0, ALL,      NON,      4, 5'b10000, 5'b10000, 1, 0);
        row(0,0,0, ALL,      NON,      0, 5'b00001, 5'b00001, 0, 0);
        row(0,0,0, ALL,      NON,      1, 5'b00010, 5'b00010, 0, 0);
        row(0,0,0, ALL,      NON,      2, 5'b00100, 5'b00100, 0, 0);
        row(1,1,0, ALL,      NON,      3, 5'b01000, 5'b00000, 0, 0);
        row(0,0,0, ALL,      NON,      0, 5'b00001, 5'b00001, 0, 0);
        row(0,0,0, ALL,      NON,      1, 5'b00010, 5'b00010, 0, 0);
        row(0,0,1, ALL,      NON,      2, 5'b00100, 5'b00100, 0, 0);
        row(0,0,1, ALL,      NON,      3, 5'b01000, 5'b01000, 0, 0);
        row(0,0,1, ALL,      NON,      4, 5'b10000, 5'b10000, 1, 0);
        row(0,0,1, ALL,      NON,      0, 5'b00000, 5'b00000, 0, 1);
        row(0,0,0, ALL,      NON,      0, 5'b00000, 5'b00000, 0, 1);
        row(0,0,0, ALL,      NON,      0, 5'b00001, 5'b00001, 0, 0);
        row(0,0,0, ALL,      NON,      1, 5'b00010, 5'b00010, 0, 0);
        row(0,0,0, ALL,      NON,      2, 5'b00100, 5'b00100, 0, 0);
        row(0,0,0, ALL,      NON,      3, 5'b01000, 5'b01000, 0, 0);
        row(0,1,1, ALL,      NON,      4, 5'b10000, 5'b00000, 0, 0);
        row(0,0,1, ALL,      NON,      0, 5'b00001, 5'b00001, 0, 0);
        row(0,0,0, ALL,      NON,      1, 5'b00010, 5'b00010, 0, 0);
        row(0,0,0, ALL,      NON,      2, 5'b00100, 5'b00100, 0, 0);
        row(0,0,0, ALL,      NON,      3, 5'b01000, 5'b01000, 0, 0);
        row(0,0,0, ALL,      NON,      4, 5'b10000, 5'b10000, 1, 0);
        row(0,1,0, ALL,      NON,      0, 5'b00001, 5'b00000, 0, 0);
        row(0,0,0, ALL,      NON,      0, 5'b00001, 5'b00001, 0, 0);

        // ---------------- Reset state ----------------
        model_reset();
        #3;
        check("reset_idx",     32'(stage_idx),    32'd0);
        check("reset_act",     32'(stage_act),    32'd0);
        check("reset_commit",  32'(stage_commit), 32'd0);
        check("reset_retire",  32'(inst_retire),  32'd0);
        check("reset_halted",  32'(halted),       32'd0);
        check("reset_retired_cnt", retired_cnt,   32'd0);
        check("reset_stall_cnt",   stall_cnt,     32'd0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- Start-up latency ----------------
        apply(0, 0, 0, ALL, NON);
        model_compare();
        check("boot_act_before_edge1", 32'(stage_act), 32'd0);
        advance();
        check("boot_act_after_edge1", 32'(stage_act), 32'd0);
        apply(0, 0, 0, ALL, NON);
        model_compare();
        advance();
        check("boot_act_after_edge2", 32'(stage_act), 32'd1);

        // ---------------- Free-running: 20 RUN cycles ----------------
        for (int i = 0; i < 20; i++) begin
            apply(0, 0, 0, ALL, NON);
            model_compare();
            check("run_idx",    32'(stage_idx),   32'(i % 5));
            check("run_retire", 32'(inst_retire), 32'((i % 5) == 4));
            advance();
        end
        check("run_retired_cnt_20", retired_cnt, exp_cnt(4));

        // ---------------- Directed table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].st, vecs[i].fl, vecs[i].hl, vecs[i].rdy, vecs[i].skp);
            check($sformatf("vec%0d_idx", i),    32'(stage_idx),    32'(vecs[i].e_idx));
            check($sformatf("vec%0d_act", i),    32'(stage_act),    32'(vecs[i].e_act));
            check($sformatf("vec%0d_commit", i), 32'(stage_commit), 32'(vecs[i].e_com));
            check($sformatf("vec%0d_retire", i), 32'(inst_retire),  32'(vecs[i].e_ret));
            check($sformatf("vec%0d_halted", i), 32'(halted),       32'(vecs[i].e_halted));
            model_compare();
            advance();
        end
        check("table_retired_cnt", retired_cnt, exp_cnt(8));
        check("table_stall_cnt",   stall_cnt,   exp_cnt(3));

        // ---------------- Randomised run against the model ----------------
        hl_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            logic          st;
            logic          fl;
            logic [NS-1:0] rdy;
            logic [NS-1:0] skp;
            st  = ($urandom_range(0, 7) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) hl_r = ~hl_r;
            rdy = NS'($urandom | $urandom);
            skp = NS'($urandom & $urandom);
            apply(st, fl, hl_r, rdy, skp);
            model_compare();
            advance();
        end

        // ---------------- Reset in the middle of stage 3 ----------------
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            apply(0, 0, 0, ALL, NON);
            if (m_running && m_stage == 3) begin
                reached = 1'b1;
            end else begin
                model_compare();
                advance();
            end
        end
        check("reach_stage3_for_reset", 32'(reached), 32'd1);
        check("pre_reset_commit3", 32'(stage_commit), 32'b01000);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_idx",     32'(stage_idx),    32'd0);
        check("midrst_act",     32'(stage_act),    32'd0);
        check("midrst_commit",  32'(stage_commit), 32'd0);
        check("midrst_retire",  32'(inst_retire),  32'd0);
        check("midrst_halted",  32'(halted),       32'd0);
        check("midrst_retired_cnt", retired_cnt,   32'd0);
        check("midrst_stall_cnt",   stall_cnt,     32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Restart: two idle edges, then instructions again from stage 0.
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, ALL, NON);
            model_compare();
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, ALL, NON);
            model_compare();
            check("restart_idx", 32'(stage_idx), 32'(i));
            // Two-stage instance: every stage-0 commit retires.
            check("two_stage_idx",    32'(idx2),    32'd0);
            check("two_stage_commit", 32'(commit2), 32'b01);
            check("two_stage_retire", 32'(retire2), 32'd1);
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stage_sequencer
